// File: rtl/uart_pkg.sv
// Shared UART definitions for the receive and transmit paths.
// Contents:
//   uart_state_e      receiver FSM state encoding (2 bits)
//   UART_IDLE         idle line level, also the required stop-bit level
//   UART_OVERSAMPLE   sample ticks per bit
//   UART_FRAME_WIDTH  data bits per frame
package uart_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } uart_state_e;

    localparam logic UART_IDLE        = 1'b1;
    localparam int   UART_OVERSAMPLE  = 16;
    localparam int   UART_FRAME_WIDTH = 8;

endpackage

// File: rtl/uart_rx_sync.sv
// rx_sync: two-flop synchroniser for an asynchronous single-bit input.
// Both flops reset to RST_VAL so the line looks idle straight out of reset.
// Ports:
//   clk  in   system clock
//   rst  in   synchronous reset, active-high
//   d    in   asynchronous input
//   q    out  synchronised output (two clocks of latency)
module rx_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver, FRAME_WIDTH data bits LSB first,
// one stop bit, no parity.
// Ports:
//   clk          in   system clock
//   rst          in   synchronous reset, active-high
//   en           in   sample tick, OVERSAMPLE x baud, one clk wide
//   rx           in   asynchronous serial input
//   data         out  last good frame, LSB = first bit received
//   valid        out  one-clk pulse: data updated
//   framing_err  out  one-clk pulse: stop bit was not IDLE
//   busy         out  high while a frame is in progress
module uart_rx
    import uart_pkg::*;
#(
    parameter int   FRAME_WIDTH      = UART_FRAME_WIDTH,
    parameter int   OVERSAMPLE       = UART_OVERSAMPLE,
    parameter int   SAMPLE_CNT_WIDTH = 4,
    parameter int   BIT_CNT_WIDTH    = 4,
    parameter logic IDLE             = UART_IDLE
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   rx,
    output logic [FRAME_WIDTH-1:0] data,
    output logic                   valid,
    output logic                   framing_err,
    output logic                   busy
);

    localparam logic [SAMPLE_CNT_WIDTH-1:0] CNT_ZERO  = SAMPLE_CNT_WIDTH'(0);
    localparam logic [SAMPLE_CNT_WIDTH-1:0] CNT_ONE   = SAMPLE_CNT_WIDTH'(1);
    localparam logic [SAMPLE_CNT_WIDTH-1:0] CNT_HALF  = SAMPLE_CNT_WIDTH'(OVERSAMPLE / 2 - 1);
    localparam logic [SAMPLE_CNT_WIDTH-1:0] CNT_LAST  = SAMPLE_CNT_WIDTH'(OVERSAMPLE - 1);
    localparam logic [BIT_CNT_WIDTH-1:0]    BIT_ZERO  = BIT_CNT_WIDTH'(0);
    localparam logic [BIT_CNT_WIDTH-1:0]    BIT_ONE   = BIT_CNT_WIDTH'(1);
    localparam logic [BIT_CNT_WIDTH-1:0]    BIT_LAST  = BIT_CNT_WIDTH'(FRAME_WIDTH - 1);
    localparam logic [FRAME_WIDTH-1:0]      DATA_ZERO = FRAME_WIDTH'(0);

    logic                        rx_s;
    uart_state_e                 state_q, state_d;
    logic [SAMPLE_CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [BIT_CNT_WIDTH-1:0]    bit_cnt_q, bit_cnt_d;
    logic [FRAME_WIDTH-1:0]      shift_q, shift_d;
    logic [FRAME_WIDTH-1:0]      data_q, data_d;
    logic                        valid_q, valid_d;
    logic                        ferr_q, ferr_d;
    logic                        busy_q, busy_d;

    rx_sync #(.RST_VAL(IDLE)) u_rx_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    // Next-state, counter, shift-register and output computation.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = 1'b0;   // pulses last one clock whether or not a tick follows
        ferr_d    = 1'b0;

        if (en) begin
            case (state_q)
                S_IDLE: begin
                    if (rx_s == ~IDLE) begin
                        state_d = S_START;
                        cnt_d   = CNT_ZERO;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_START: begin
                    if (cnt_q == CNT_HALF) begin
                        cnt_d     = CNT_ZERO;
                        bit_cnt_d = BIT_ZERO;
                        // Line back at IDLE by mid start bit means it was a glitch.
                        if (rx_s == ~IDLE) begin
                            state_d = S_DATA;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                S_DATA: begin
                    if (cnt_q == CNT_LAST) begin
                        // Right shift: the first bit received ends up in the LSB.
                        shift_d   = {rx_s, shift_q[FRAME_WIDTH-1:1]};
                        bit_cnt_d = bit_cnt_q + BIT_ONE;
                        cnt_d     = CNT_ZERO;
                        if (bit_cnt_q == BIT_LAST) begin
                            state_d = S_STOP;
                        end else begin
                            state_d = S_DATA;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                S_STOP: begin
                    if (cnt_q == CNT_LAST) begin
                        // Leave at mid stop bit so a back-to-back start edge is caught.
                        state_d = S_IDLE;
                        cnt_d   = CNT_ZERO;
                        if (rx_s == IDLE) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end else begin
                            ferr_d  = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = CNT_ZERO;
                end
            endcase
        end else begin
            state_d = state_q;
        end

        // Registered from next state so busy falls with the valid/framing_err edge.
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= CNT_ZERO;
            bit_cnt_q <= BIT_ZERO;
            shift_q   <= DATA_ZERO;
            data_q    <= DATA_ZERO;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            busy_q    <= busy_d;
        end
    end

    assign data        = data_q;
    assign valid       = valid_q;
    assign framing_err = ferr_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx: OVERSAMPLE=16, FRAME_WIDTH=8, en every 4th clock,
// so one bit time is 64 clocks.
module tb_uart_rx;

    localparam int BIT_CLKS = 64;

    logic       clk;
    logic       rst;
    logic       en;
    logic       rx;
    logic [7:0] data;
    logic       valid;
    logic       framing_err;
    logic       busy;

    int checks;
    int passes;
    int n_valid;
    int n_ferr;
    logic [7:0] last_good;

    typedef struct {
        logic [7:0] frame;
        logic       stop;
        int         gap_bits;
        logic [7:0] exp_data;
        int         exp_valid;
        int         exp_ferr;
    } vec_t;

    vec_t vecs[4];

    uart_rx dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .rx          (rx),
        .data        (data),
        .valid       (valid),
        .framing_err (framing_err),
        .busy        (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        en = 1'b0;
        forever begin
            repeat (3) @(posedge clk);
            #1 en = 1'b1;
            @(posedge clk);
            #1 en = 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Pulse monitor: counts pulses and checks their shape against busy.
    initial begin
        logic prev_busy;
        logic prev_valid;
        logic prev_ferr;
        prev_busy  = 1'b0;
        prev_valid = 1'b0;
        prev_ferr  = 1'b0;
        forever begin
            @(negedge clk);
            if (valid === 1'b1) begin
                n_valid++;
                chk("busy_low_on_valid", {31'd0, busy}, 32'd0);
                chk("busy_high_before_valid", {31'd0, prev_busy}, 32'd1);
                chk("valid_one_clk", {31'd0, prev_valid}, 32'd0);
                chk("no_ferr_with_valid", {31'd0, framing_err}, 32'd0);
            end
            if (framing_err === 1'b1) begin
                n_ferr++;
                chk("busy_low_on_ferr", {31'd0, busy}, 32'd0);
                chk("ferr_one_clk", {31'd0, prev_ferr}, 32'd0);
            end
            prev_busy  = busy;
            prev_valid = valid;
            prev_ferr  = framing_err;
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        wait_clks(BIT_CLKS);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input int gap_bits);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            drive_bit(b[i]);
        end
        drive_bit(stop);
        rx = 1'b1;
        wait_clks(gap_bits * BIT_CLKS);
    endtask

    // Send one frame and check the result against the frame-level model:
    // a high stop bit delivers the byte, a low one flags an error and keeps the old byte.
    task automatic run_frame(input string name, input logic [7:0] b, input logic stop,
                             input int gap_bits, input logic [7:0] exp_data,
                             input int exp_valid, input int exp_ferr);
        int v0;
        int f0;
        v0 = n_valid;
        f0 = n_ferr;
        send_frame(b, stop, gap_bits);
        chk({name, "_valid_cnt"}, n_valid - v0, exp_valid);
        chk({name, "_ferr_cnt"}, n_ferr - f0, exp_ferr);
        chk({name, "_data"}, {24'd0, data}, {24'd0, exp_data});
        if (gap_bits > 0) begin
            chk({name, "_busy_idle"}, {31'd0, busy}, 32'd0);
        end else begin
            checks = checks;
        end
    endtask

    task automatic glitch_test();
        int v0;
        int f0;
        v0 = n_valid;
        f0 = n_ferr;
        rx = 1'b0;
        wait_clks(16);          // 4 ticks low
        rx = 1'b1;
        wait_clks(4);
        chk("glitch_busy_mid", {31'd0, busy}, 32'd1);
        wait_clks(28);          // 12 ticks after the falling edge
        chk("glitch_busy_low", {31'd0, busy}, 32'd0);
        wait_clks(BIT_CLKS);
        chk("glitch_valid_cnt", n_valid - v0, 32'd0);
        chk("glitch_ferr_cnt", n_ferr - f0, 32'd0);
        chk("glitch_data", {24'd0, data}, {24'd0, last_good});
    endtask

    initial begin
        logic [7:0] rb;
        logic       rs;
        int         rg;
        logic [7:0] abort_b;
        int         v0;
        int         f0;

        checks    = 0;
        passes    = 0;
        n_valid   = 0;
        n_ferr    = 0;
        last_good = 8'h00;
        rst       = 1'b1;
        rx        = 1'b0;

        // 1. Reset with rx toggling.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1 rx = ~rx;
            chk("rst_data", {24'd0, data}, 32'd0);
            chk("rst_valid", {31'd0, valid}, 32'd0);
            chk("rst_ferr", {31'd0, framing_err}, 32'd0);
            chk("rst_busy", {31'd0, busy}, 32'd0);
        end
        rst = 1'b0;
        rx  = 1'b1;
        wait_clks(2 * BIT_CLKS);

        // 2, 4, 5 as table entries; 3 (glitch) runs after the first frame.
        vecs[0] = '{frame: 8'hA5, stop: 1'b1, gap_bits: 2, exp_data: 8'hA5, exp_valid: 1, exp_ferr: 0};
        vecs[1] = '{frame: 8'h3C, stop: 1'b0, gap_bits: 2, exp_data: 8'hA5, exp_valid: 0, exp_ferr: 1};
        vecs[2] = '{frame: 8'h00, stop: 1'b1, gap_bits: 0, exp_data: 8'h00, exp_valid: 1, exp_ferr: 0};
        vecs[3] = '{frame: 8'hFF, stop: 1'b1, gap_bits: 2, exp_data: 8'hFF, exp_valid: 1, exp_ferr: 0};

        for (int i = 0; i < 4; i++) begin
            if (i == 1) begin
                glitch_test();
            end
            run_frame($sformatf("vec%0d", i), vecs[i].frame, vecs[i].stop, vecs[i].gap_bits,
                      vecs[i].exp_data, vecs[i].exp_valid, vecs[i].exp_ferr);
            if (vecs[i].stop) begin
                last_good = vecs[i].frame;
            end
        end

        // Random frames against the frame-level model.
        for (int i = 0; i < 10; i++) begin
            rb = 8'($urandom);
            rs = ($urandom_range(0, 3) != 0);
            rg = rs ? ($urandom_range(0, 1) * 2) : 2;
            if (rs) begin
                last_good = rb;
            end
            run_frame($sformatf("rnd%0d", i), rb, rs, rg, last_good,
                      rs ? 1 : 0, rs ? 0 : 1);
        end

        // 6. Reset during data bit 4 discards the frame and clears data.
        v0 = n_valid;
        f0 = n_ferr;
        abort_b = 8'h77;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) begin
            drive_bit(abort_b[i]);
        end
        rx = abort_b[4];
        wait_clks(BIT_CLKS / 2);
        chk("abort_busy_before_rst", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        wait_clks(1);
        rst = 1'b0;
        rx  = 1'b1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_data", {24'd0, data}, 32'd0);
        wait_clks(3 * BIT_CLKS);
        chk("abort_valid_cnt", n_valid - v0, 32'd0);
        chk("abort_ferr_cnt", n_ferr - f0, 32'd0);
        chk("abort_busy_idle", {31'd0, busy}, 32'd0);
        run_frame("after_abort", 8'h5A, 1'b1, 2, 8'h5A, 1, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
